// File: rtl/icache_pkg.sv
// icache_pkg: widths shared with the RAM controller and the cache controller state type.
package icache_pkg;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned INDEX_BITS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } icache_state_e;
endpackage

// File: rtl/icache_store.sv
// icache_store: direct-mapped valid/tag/data arrays, combinational lookup, synchronous fill.
module icache_store #(
  parameter int unsigned ADDR_W     = icache_pkg::ADDR_W,
  parameter int unsigned INST_W     = icache_pkg::INST_W,
  parameter int unsigned INDEX_BITS = icache_pkg::INDEX_BITS
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_rdy,
  input  logic [INDEX_BITS-1:0]          i_rd_idx,
  input  logic [ADDR_W-INDEX_BITS-3:0]   i_rd_tag,
  output logic                           o_rd_hit,
  output logic [INST_W-1:0]              o_rd_data,
  input  logic                           i_wr_en,
  input  logic [INDEX_BITS-1:0]          i_wr_idx,
  input  logic [ADDR_W-INDEX_BITS-3:0]   i_wr_tag,
  input  logic [INST_W-1:0]              i_wr_data
);
  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = ADDR_W - INDEX_BITS - 2;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [INST_W-1:0] r_data [LINES];

  assign o_rd_hit  = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_data = r_data[i_rd_idx];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (i_rdy && i_wr_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag/data survive reset; only the valid bits are cleared.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_rdy && i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end
endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one word per line, single outstanding RAM read.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache #(
  parameter int unsigned ADDR_W     = icache_pkg::ADDR_W,
  parameter int unsigned INST_W     = icache_pkg::INST_W,
  parameter int unsigned INDEX_BITS = icache_pkg::INDEX_BITS
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_rdy_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rdy_i,
  input  logic [INST_W-1:0] mem_inst_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       stat_hit_o,
  output logic [31:0]       stat_miss_o
`endif
);
  import icache_pkg::*;

  icache_state_e     r_state;
  icache_state_e     w_state_nxt;
  logic              w_hit;
  logic [INST_W-1:0] w_hit_data;
  logic              w_lookup;
  logic              w_fill;
  logic              w_rdy_nxt;
  logic [INST_W-1:0] w_inst_nxt;
  logic              w_en_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_unused;

  // A lookup is taken only when no response is showing, so a held request is not served twice.
  assign w_lookup = (r_state == IDLE) && if_req_i && !if_rdy_o && !if_flush_i;
  assign w_fill   = (r_state != IDLE) && mem_rdy_i;
  assign w_unused = ^{if_addr_i[1:0], mem_addr_o[1:0]};

  icache_store #(
    .ADDR_W     (ADDR_W),
    .INST_W     (INST_W),
    .INDEX_BITS (INDEX_BITS)
  ) u_store (
    .i_clk     (clk_in),
    .i_rst_n   (rst_in),
    .i_rdy     (rdy_in),
    .i_rd_idx  (if_addr_i[INDEX_BITS+1:2]),
    .i_rd_tag  (if_addr_i[ADDR_W-1:INDEX_BITS+2]),
    .o_rd_hit  (w_hit),
    .o_rd_data (w_hit_data),
    .i_wr_en   (w_fill),
    .i_wr_idx  (mem_addr_o[INDEX_BITS+1:2]),
    .i_wr_tag  (mem_addr_o[ADDR_W-1:INDEX_BITS+2]),
    .i_wr_data (mem_inst_i)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= IDLE;
      if_rdy_o   <= 1'b0;
      if_inst_o  <= '0;
      mem_en_o   <= 1'b0;
      mem_addr_o <= '0;
    end else if (rdy_in) begin
      r_state    <= w_state_nxt;
      if_rdy_o   <= w_rdy_nxt;
      if_inst_o  <= w_inst_nxt;
      mem_en_o   <= w_en_nxt;
      mem_addr_o <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_lookup && !w_hit) w_state_nxt = MISS;
      MISS:  if (mem_rdy_i) w_state_nxt = IDLE;
             else if (if_flush_i) w_state_nxt = DRAIN;
      DRAIN: if (mem_rdy_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The outstanding read is never aborted; a flush only withholds the response.
  always_comb begin
    w_rdy_nxt  = 1'b0;
    w_inst_nxt = if_inst_o;
    w_en_nxt   = mem_en_o;
    w_addr_nxt = mem_addr_o;
    case (r_state)
      IDLE: begin
        if (w_lookup) begin
          if (w_hit) begin
            w_rdy_nxt  = 1'b1;
            w_inst_nxt = w_hit_data;
          end else begin
            w_en_nxt   = 1'b1;
            w_addr_nxt = {if_addr_i[ADDR_W-1:2], 2'b00};
          end
        end
      end
      MISS: begin
        if (mem_rdy_i) begin
          w_en_nxt = 1'b0;
          if (!if_flush_i) begin
            w_rdy_nxt  = 1'b1;
            w_inst_nxt = mem_inst_i;
          end
        end
      end
      DRAIN: begin
        if (mem_rdy_i) w_en_nxt = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      stat_hit_o  <= '0;
      stat_miss_o <= '0;
    end else if (rdy_in && w_lookup) begin
      if (w_hit) stat_hit_o  <= stat_hit_o + 32'd1;
      else       stat_miss_o <= stat_miss_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed vector table plus randomized fetches checked against a line-address cache model.
module tb_icache;
  logic        clk;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_rdy_o;
  logic [31:0] if_inst_o;
  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic        mem_rdy_i;
  logic [31:0] mem_inst_i;
`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hit_o;
  logic [31:0] stat_miss_o;
`endif

  icache #(
    .ADDR_W     (32),
    .INST_W     (32),
    .INDEX_BITS (7)
  ) dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_flush_i (if_flush_i),
    .if_rdy_o   (if_rdy_o),
    .if_inst_o  (if_inst_o),
    .mem_en_o   (mem_en_o),
    .mem_addr_o (mem_addr_o),
    .mem_rdy_i  (mem_rdy_i),
    .mem_inst_i (mem_inst_i)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hit_o  (stat_hit_o),
    .stat_miss_o (stat_miss_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pulses = 0;
  int n_mem_reqs = 0;
  int n_addr_moves = 0;
  int mem_lat = 1;
  int ref_hits = 0;
  int ref_misses = 0;
  bit          ref_valid [128];
  logic [31:0] ref_line  [128];

  typedef struct {
    logic [31:0] addr;
    int          lat;
    int          flush_at;
    bit          exp_hit;
    logic [31:0] exp_inst;
  } vec_t;
  vec_t vecs [11];

  function automatic logic [31:0] ref_mem(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  function automatic int ref_index(input logic [31:0] wa);
    return int'((wa >> 2) % 32'd128);
  endfunction

  function automatic bit ref_hit(input logic [31:0] wa);
    int i;
    i = ref_index(wa);
    return ref_valid[i] && (ref_line[i] == wa);
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
  endtask

  always @(negedge clk) begin
    if (if_rdy_o === 1'b1) n_pulses++;
  end

  // RAM controller stand-in: answers each read mem_lat cycles after mem_en_o rises.
  initial begin
    int cnt;
    logic [31:0] req_addr;
    cnt = 0;
    req_addr = '0;
    mem_rdy_i = 1'b0;
    mem_inst_i = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_in) begin
        cnt = 0;
        mem_rdy_i = 1'b0;
      end else if (mem_rdy_i) begin
        mem_rdy_i = 1'b0;
        mem_inst_i = $urandom;
      end else if (mem_en_o === 1'b1) begin
        if (cnt == 0) begin
          req_addr = mem_addr_o;
          n_mem_reqs++;
        end else if (mem_addr_o !== req_addr) begin
          n_addr_moves++;
        end
        cnt++;
        if (cnt >= mem_lat) begin
          mem_rdy_i = 1'b1;
          mem_inst_i = ref_mem(mem_addr_o);
          cnt = 0;
        end
      end
    end
  end

  // flush_at: -1 none, 0 together with the request, k>0 during the k-th cycle after it.
  task automatic fetch(input string nm, input logic [31:0] a, input int lat, input int flush_at,
                       input bit exp_hit, input logic [31:0] exp_inst);
    logic [31:0] wa;
    logic [31:0] gi;
    int p0, m0, v0, at;
    bit got;
    wa = {a[31:2], 2'b00};
    p0 = n_pulses; m0 = n_mem_reqs; v0 = n_addr_moves;
    got = 1'b0; gi = '0; at = 0;
    mem_lat = lat;
    if_addr_i = a;
    if_req_i = 1'b1;
    if_flush_i = (flush_at == 0);
    for (int k = 1; k <= lat + 20; k++) begin
      @(posedge clk); #1;
      if (k == 1 && !exp_hit && flush_at != 0) begin
        check({nm, "_mem_en"}, 32'(mem_en_o), 32'd1);
        check({nm, "_mem_addr"}, mem_addr_o, wa);
      end
      if_flush_i = (k == flush_at);
      if (flush_at >= 0 && k >= flush_at) if_req_i = 1'b0;
      if (flush_at < 0 && if_rdy_o === 1'b1) begin
        got = 1'b1; gi = if_inst_o; at = k;
        break;
      end
      if (flush_at >= 0 && k > flush_at && mem_en_o === 1'b0) break;
    end
    if (flush_at < 0) begin
      check({nm, "_resp"}, 32'(got), 32'd1);
      check({nm, "_latency"}, 32'(at), exp_hit ? 32'd1 : 32'(lat + 1));
      check({nm, "_inst"}, gi, exp_inst);
      @(posedge clk); #1;
      check({nm, "_single"}, 32'(if_rdy_o), 32'd0);
    end else begin
      check({nm, "_drained"}, 32'(mem_en_o), 32'd0);
    end
    if_req_i = 1'b0;
    if_flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_pulses"}, 32'(n_pulses - p0), (flush_at < 0) ? 32'd1 : 32'd0);
    check({nm, "_mem_reqs"}, 32'(n_mem_reqs - m0), (exp_hit || flush_at == 0) ? 32'd0 : 32'd1);
    check({nm, "_addr_stable"}, 32'(n_addr_moves - v0), 32'd0);
    if (flush_at != 0) begin
      if (exp_hit) ref_hits++;
      else begin
        ref_misses++;
        ref_valid[ref_index(wa)] = 1'b1;
        ref_line[ref_index(wa)] = wa;
      end
    end
  endtask

  initial begin
    int p0, m0, lat, fa;
    logic [1:0]  t;
    logic [2:0]  ix;
    logic [1:0]  lo;
    logic [31:0] a, wa;
    bit eh;

    vecs[0]  = '{32'h0000_0000, 8, -1, 1'b0, 32'h0000_0013};
    vecs[1]  = '{32'h0000_0000, 3, -1, 1'b1, 32'h0000_0013};
    vecs[2]  = '{32'h0000_0200, 4, -1, 1'b0, 32'h0000_0213};
    vecs[3]  = '{32'h0000_0000, 2, -1, 1'b0, 32'h0000_0013};
    vecs[4]  = '{32'h0000_0040, 6,  2, 1'b0, 32'h0000_0000};
    vecs[5]  = '{32'h0000_0040, 5, -1, 1'b1, 32'h0000_0053};
    vecs[6]  = '{32'h0000_0088, 1,  1, 1'b0, 32'h0000_0000};
    vecs[7]  = '{32'h0000_0088, 3, -1, 1'b1, 32'h0000_009B};
    vecs[8]  = '{32'h0000_02C4, 2,  0, 1'b0, 32'h0000_0000};
    vecs[9]  = '{32'h0000_02C6, 2, -1, 1'b0, 32'h0000_02D7};
    vecs[10] = '{32'h0000_02C4, 2, -1, 1'b1, 32'h0000_02D7};

    for (int i = 0; i < 128; i++) begin
      ref_valid[i] = 1'b0;
      ref_line[i] = '0;
    end

    rst_in = 1'b0; rdy_in = 1'b1; if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_if_rdy", 32'(if_rdy_o), 32'd0);
    check("rst_if_inst", if_inst_o, 32'd0);
    check("rst_mem_en", 32'(mem_en_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    rst_in = 1'b1;

    for (int i = 0; i < 11; i++) begin
      fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].lat, vecs[i].flush_at,
            vecs[i].exp_hit, vecs[i].exp_inst);
`ifdef ICACHE_STATS_EN
      if (i == 3) begin
        check("stat_hit_plan", stat_hit_o, 32'd1);
        check("stat_miss_plan", stat_miss_o, 32'd3);
      end
`endif
    end

    // Stall the global enable on the cycle a hit would be sampled.
    p0 = n_pulses; m0 = n_mem_reqs;
    rdy_in = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0000_0000;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("hold_no_rdy", 32'(if_rdy_o), 32'd0);
    end
    rdy_in = 1'b1;
    @(posedge clk); #1;
    check("hold_resp", 32'(if_rdy_o), 32'd1);
    check("hold_inst", if_inst_o, 32'h0000_0013);
    @(posedge clk); #1;
    check("hold_single", 32'(if_rdy_o), 32'd0);
    if_req_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("hold_pulses", 32'(n_pulses - p0), 32'd1);
    check("hold_mem_reqs", 32'(n_mem_reqs - m0), 32'd0);
    ref_hits++;

    for (int n = 0; n < 80; n++) begin
      t  = 2'($urandom_range(0, 3));
      ix = 3'($urandom_range(0, 7));
      lo = 2'($urandom_range(0, 3));
      a  = {21'd0, t, 4'd0, ix, lo};
      wa = {a[31:2], 2'b00};
      eh = ref_hit(wa);
      lat = int'($urandom_range(1, 6));
      fa = int'($urandom_range(0, 9));
      if (fa == 0) fa = 0;
      else if (fa <= 2 && !eh) fa = int'($urandom_range(1, lat));
      else fa = -1;
      fetch($sformatf("rnd%0d", n), a, lat, fa, eh, ref_mem(wa));
    end

`ifdef ICACHE_STATS_EN
    check("stat_hit_total", stat_hit_o, 32'(ref_hits));
    check("stat_miss_total", stat_miss_o, 32'(ref_misses));
`endif

    rst_in = 1'b0;
    @(posedge clk); #1;
    check("rst2_if_rdy", 32'(if_rdy_o), 32'd0);
    check("rst2_if_inst", if_inst_o, 32'd0);
    check("rst2_mem_en", 32'(mem_en_o), 32'd0);
    check("rst2_mem_addr", mem_addr_o, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst2_stat_hit", stat_hit_o, 32'd0);
    check("rst2_stat_miss", stat_miss_o, 32'd0);
`endif
    rst_in = 1'b1;
    for (int i = 0; i < 128; i++) ref_valid[i] = 1'b0;
    fetch("post_rst", 32'h0000_0000, 3, -1, 1'b0, 32'h0000_0013);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped instruction cache between the instruction-fetch stage (upstream) and the byte-serial RAM controller (downstream).
- Hits are served in one cycle.
- Misses issue a single 32-bit instruction read to the RAM controller, fill the line and return the word.
- One 32-bit word per line; no writes, no coherence with data stores.

Parameters:
ADDR_W, 32, address width
INST_W, 32, instruction/line width
INDEX_BITS, 7, log2(number of lines); index = addr[INDEX_BITS+1:2], tag = addr[ADDR_W-1:INDEX_BITS+2]

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, synchronous, active-low
rdy_in  in  1  global enable; when 0 every register holds
if_req_i  in  1  fetch request, level, held with if_addr_i until if_rdy_o
if_addr_i  in  ADDR_W  fetch PC, word-aligned (bits [1:0] ignored)
if_flush_i  in  1  cancel current request (branch redirect)
if_rdy_o  out  1  one-cycle pulse: if_inst_o valid
if_inst_o  out  INST_W  fetched instruction
mem_en_o  out  1  read request to RAM controller, held until mem_rdy_i
mem_addr_o  out  ADDR_W  word address, low 2 bits zero, stable while mem_en_o
mem_rdy_i  in  1  RAM controller read complete (one-cycle pulse)
mem_inst_i  in  INST_W  read data, valid with mem_rdy_i

Behaviour:
- All activity is gated by rdy_in=1. With rdy_in=0, state, arrays and outputs hold.
- Reset (rst_in=0 at posedge): all valid bits 0, state IDLE, if_rdy_o 0, if_inst_o 0, mem_en_o 0, mem_addr_o 0. Tag/data arrays are not cleared.
- Reset mid-miss: mem_en_o drops at that edge. The RAM controller shares the reset.
- States: IDLE, MISS, DRAIN.
- IDLE:
  - if_req_i is sampled only when if_rdy_o=0 in the current cycle. This prevents double-serving a held request.
  - Hit (valid[idx] and tag match): next cycle if_rdy_o=1, if_inst_o=data[idx]. Latency 1.
  - Miss: next cycle mem_en_o=1, mem_addr_o={if_addr_i[ADDR_W-1:2],2'b00}; go MISS.
- MISS:
  - mem_en_o and mem_addr_o are held stable, as the RAM controller requires.
  - On mem_rdy_i: write valid/tag/data[idx]; mem_en_o<=0; if_rdy_o<=1, if_inst_o<=mem_inst_i; go IDLE.
  - Miss latency = RAM controller latency + 1.
- DRAIN:
  - Same as MISS, except on mem_rdy_i the line is filled, if_rdy_o stays 0, then go IDLE.
- if_flush_i rules:
  - IDLE: no lookup that cycle; any pending hit response is suppressed (if_rdy_o<=0).
  - MISS: go DRAIN. The outstanding memory read is never aborted.
  - Flush and mem_rdy_i at the same edge in MISS: fill, no if_rdy_o, go IDLE.
- mem_en_o is low for at least one cycle between consecutive requests, guaranteed by returning to IDLE.
- if_rdy_o is never high two consecutive cycles for the same request.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs stat_hit_o[31:0] and stat_miss_o[31:0].
  - Counters increment on each IDLE lookup that hits/misses. Flushed cycles are not counted.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package: ADDR_W/INST_W constants (shared with the RAM controller) and the icache state typedef (IDLE/MISS/DRAIN).
- One sub-module: icache_store, holding valid/tag/data arrays, with a combinational read port (hit, data) and a synchronous write port.
- The FSM lives in icache.

Test Plan:
1. After reset, req 0x0000_0000; memory answers 0x0000_0013 after 8 cycles -> mem_en_o=1 with mem_addr_o=0x0 until mem_rdy_i; if_rdy_o pulses once with 0x0000_0013 one cycle after mem_rdy_i.
2. Re-request 0x0000_0000 -> if_rdy_o pulse one cycle after sample, if_inst_o=0x0000_0013, mem_en_o stays 0.
3. Conflict: req 0x0000_0200 (same index, INDEX_BITS=7) -> miss, line replaced; next req 0x0000_0000 misses again.
4. if_flush_i pulse 2 cycles into a miss on 0x0000_0040 -> mem_en_o/mem_addr_o held until mem_rdy_i, no if_rdy_o; a later req 0x0000_0040 hits.
5. rdy_in=0 for 3 cycles on the cycle a hit is sampled -> if_rdy_o deferred 3 cycles, still single pulse. Flush coincident with mem_rdy_i -> no if_rdy_o, state IDLE.
6. ICACHE_STATS_EN defined, sequence of tests 1–3 -> stat_hit_o=1, stat_miss_o=3. Assert rst_in=0 -> both 0.
